// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with 16x oversampling and a small first-word-fall-through byte FIFO.
// Everything runs on clk_sys_i with a synchronous active-high reset.
`timescale 1ns/1ps
module uart_rx_deframer #(
    parameter int ClkFreq   = 50_000_000,
    parameter int BaudRate  = 115200,
    parameter int FifoDepth = 4
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_i,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overflow_o
);

    localparam int DivRaw = ClkFreq / (BaudRate * 16);
    localparam int Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int CntW   = (Div > 1) ? $clog2(Div) : 1;
    localparam int AddrW  = $clog2(FifoDepth);
    localparam int PtrW   = AddrW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic            r_sync1;
    logic            r_rx_s;
    logic [CntW-1:0] r_tick_cnt;
    logic            w_tick;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == CntW'(Div - 1));

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    state_t      r_state;
    logic [3:0]  r_sample;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_push;
    logic        r_frame_err;

    // Sample count 7 after the detected edge is mid start bit; every further
    // 16 ticks lands mid-bit on the data and stop bits.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state     <= S_IDLE;
            r_sample    <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (!r_rx_s) begin
                            r_state  <= S_START;
                            r_sample <= '0;
                        end
                    end
                    S_START: begin
                        if (r_sample == 4'd7) begin
                            r_sample <= '0;
                            if (!r_rx_s) begin
                                r_state   <= S_DATA;
                                r_bit_idx <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_sample <= r_sample + 4'd1;
                        end
                    end
                    S_DATA: begin
                        r_sample <= r_sample + 4'd1;
                        if (r_sample == 4'd15) begin
                            r_shift   <= {r_rx_s, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end
                    end
                    S_STOP: begin
                        r_sample <= r_sample + 4'd1;
                        if (r_sample == 4'd15) begin
                            if (r_rx_s) begin
                                r_push  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    logic [7:0]      r_mem [FifoDepth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic            r_overflow;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]) &&
                     (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]);
    assign w_pop   = !w_empty && rx_ready_i;
    // A pop in the same cycle frees the head slot, so a full FIFO still takes the byte.
    assign w_wr_en = r_push && (!w_full || w_pop);

    // NOTE: the storage is reset on purpose so rx_data_o reads 0 after reset;
    // a plain RAM without reset would be smaller but leave the head undefined.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FifoDepth; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_overflow <= r_push && w_full && !w_pop;
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AddrW-1:0]] <= r_shift;
                r_wr_ptr                   <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

    assign rx_data_o   = r_mem[r_rd_ptr[AddrW-1:0]];
    assign rx_valid_o  = !w_empty;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 16 clocks per bit (Div=1).
`timescale 1ns/1ps
module tb_uart_rx_deframer;

    localparam int ClkFreq   = 1_600_000;
    localparam int BaudRate  = 100_000;
    localparam int FifoDepth = 4;

    logic       clk_sys_i  = 1'b0;
    logic       rst_sys_i  = 1'b1;
    logic       uart_rx_i  = 1'b1;
    logic       rx_ready_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       frame_err_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int rise_cyc = 0;
    logic prev_valid = 1'b0;

    uart_rx_deframer #(
        .ClkFreq  (ClkFreq),
        .BaudRate (BaudRate),
        .FifoDepth(FifoDepth)
    ) dut (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_i  (rst_sys_i),
        .uart_rx_i  (uart_rx_i),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .frame_err_o(frame_err_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    always @(posedge clk_sys_i) cyc <= cyc + 1;

    // Pulse counters and rx_valid_o rising-edge timestamp.
    always @(negedge clk_sys_i) begin
        if (frame_err_o) fe_cnt = fe_cnt + 1;
        if (overflow_o)  ov_cnt = ov_cnt + 1;
        if (rx_valid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid_o;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys_i);
    endtask

    // Called on a negedge; drives one 8N1 frame, 16 clocks per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx_i = 1'b0;
        repeat (16) @(negedge clk_sys_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (16) @(negedge clk_sys_i);
        end
        uart_rx_i = stop_bit;
        repeat (16) @(negedge clk_sys_i);
        uart_rx_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_sys_i = 1'b1;
        idle(3);
        n_checks++;
        if (rx_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid_o);
        end
        n_checks++;
        if (rx_data_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data_o);
        end
        n_checks++;
        if (frame_err_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got fe=%b ov=%b expected 0 0", frame_err_o, overflow_o);
        end
        rst_sys_i = 1'b0;
        idle(5);
    endtask

    task automatic test_single();
        int start_cyc;
        int lat;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        lat = rise_cyc - start_cyc;
        n_checks++;
        if (lat < 148 || lat > 158) begin
            n_fail++; $display("FAIL single_latency: got %0d expected 148..158", lat);
        end
        idle(10);
        n_checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'hA5) begin
            n_fail++; $display("FAIL single_data: got v=%b d=%h expected v=1 d=a5", rx_valid_o, rx_data_o);
        end
        rx_ready_i = 1'b1;
        @(negedge clk_sys_i);
        rx_ready_i = 1'b0;
        n_checks++;
        if (rx_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_pop: got valid=%b expected 0", rx_valid_o);
        end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        uart_rx_i = 1'b0;
        idle(4);
        uart_rx_i = 1'b1;
        idle(30);
        n_checks++;
        if (rx_valid_o !== 1'b0 || fe_cnt != fe0) begin
            n_fail++; $display("FAIL glitch_quiet: got valid=%b fe=%0d expected 0 0", rx_valid_o, fe_cnt - fe0);
        end
        send_frame(8'h3C, 1'b1);
        idle(4);
        n_checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h3C) begin
            n_fail++; $display("FAIL glitch_next: got v=%b d=%h expected v=1 d=3c", rx_valid_o, rx_data_o);
        end
        rx_ready_i = 1'b1;
        @(negedge clk_sys_i);
        rx_ready_i = 1'b0;
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        uart_rx_i = 1'b0;
        idle(40);
        uart_rx_i = 1'b1;
        idle(20);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin
            n_fail++; $display("FAIL ferr_pulse: got %0d pulses expected 1", fe_cnt - fe0);
        end
        n_checks++;
        if (rx_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL ferr_empty: got valid=%b expected 0", rx_valid_o);
        end
        send_frame(8'h01, 1'b1);
        idle(4);
        n_checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h01 || fe_cnt - fe0 != 1) begin
            n_fail++; $display("FAIL ferr_next: got v=%b d=%h fe=%0d expected v=1 d=01 fe=1",
                               rx_valid_o, rx_data_o, fe_cnt - fe0);
        end
        rx_ready_i = 1'b1;
        @(negedge clk_sys_i);
        rx_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        int ov0;
        logic [7:0] exp_q [4];
        ov0 = ov_cnt;
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
        idle(4);
        n_checks++;
        if (ov_cnt - ov0 != 1) begin
            n_fail++; $display("FAIL ovf_pulse: got %0d pulses expected 1", ov_cnt - ov0);
        end
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        rx_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_valid_o !== 1'b1 || rx_data_o !== exp_q[i]) begin
                n_fail++; $display("FAIL ovf_drain%0d: got v=%b d=%h expected v=1 d=%h",
                                   i, rx_valid_o, rx_data_o, exp_q[i]);
            end
            @(negedge clk_sys_i);
        end
        rx_ready_i = 1'b0;
        n_checks++;
        if (rx_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_empty: got valid=%b expected 0", rx_valid_o);
        end
    endtask

    task automatic test_full_pop();
        int ov0;
        logic [7:0] exp_q [4];
        ov0 = ov_cnt;
        for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 1'b1);
        // The 0x77 push lands on the posedge 156 clocks after the start edge is driven.
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (155) @(negedge clk_sys_i);
                rx_ready_i = 1'b1;
                @(negedge clk_sys_i);
                rx_ready_i = 1'b0;
            end
        join
        idle(4);
        n_checks++;
        if (ov_cnt != ov0) begin
            n_fail++; $display("FAIL fullpop_ovf: got %0d pulses expected 0", ov_cnt - ov0);
        end
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h77};
        rx_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_valid_o !== 1'b1 || rx_data_o !== exp_q[i]) begin
                n_fail++; $display("FAIL fullpop_drain%0d: got v=%b d=%h expected v=1 d=%h",
                                   i, rx_valid_o, rx_data_o, exp_q[i]);
            end
            @(negedge clk_sys_i);
        end
        rx_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        int ov0;
        logic [7:0] exp_b;
        ov0 = ov_cnt;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) send_frame(8'h80 + 8'(4 * k + i), 1'b1);
            idle(4);
            rx_ready_i = 1'b1;
            for (int i = 0; i < 4; i++) begin
                exp_b = 8'h80 + 8'(4 * k + i);
                n_checks++;
                if (rx_valid_o !== 1'b1 || rx_data_o !== exp_b) begin
                    n_fail++; $display("FAIL wrap%0d_%0d: got v=%b d=%h expected v=1 d=%h",
                                       k, i, rx_valid_o, rx_data_o, exp_b);
                end
                @(negedge clk_sys_i);
            end
            rx_ready_i = 1'b0;
        end
        n_checks++;
        if (rx_valid_o !== 1'b0 || ov_cnt != ov0) begin
            n_fail++; $display("FAIL wrap_end: got valid=%b ovf=%0d expected 0 0", rx_valid_o, ov_cnt - ov0);
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h5A, 1'b1);
        send_frame(8'h6B, 1'b1);
        idle(4);
        // Data bit 3 occupies clocks 64..79 after the start edge.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (70) @(negedge clk_sys_i);
                rst_sys_i = 1'b1;
                @(negedge clk_sys_i);
                rst_sys_i = 1'b0;
                n_checks++;
                if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00) begin
                    n_fail++; $display("FAIL rstmid_flush: got v=%b d=%h expected v=0 d=00", rx_valid_o, rx_data_o);
                end
            end
        join
        idle(20);
        n_checks++;
        if (rx_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_nobyte: got valid=%b expected 0", rx_valid_o);
        end
        send_frame(8'h42, 1'b1);
        idle(4);
        n_checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h42) begin
            n_fail++; $display("FAIL rstmid_next: got v=%b d=%h expected v=1 d=42", rx_valid_o, rx_data_o);
        end
        rx_ready_i = 1'b1;
        @(negedge clk_sys_i);
        rx_ready_i = 1'b0;
        n_checks++;
        if (rx_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_alone: got valid=%b expected 0", rx_valid_o);
        end
    endtask

    initial begin
        @(negedge clk_sys_i);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
